store_buffer: RTL
=================

// Module: store_buffer
// PURPOSE
//  Posted-write buffer between the CPU load/store path and the single-ported, combinational-read DataMem.
//  Stores retire into a small FIFO; the FIFO drains to memory in cycles when the port is free.
//  Loads are served from the buffer when the address matches; otherwise they go straight to memory.
//  Same-address stores coalesce into one entry, so each address occupies at most one slot.
// PARAMETERS
//  DEPTH   4   number of buffer entries, power of two, >=2
//  ADDR_W  9   word address width; matches DataMem addr
//  DATA_W  32  data width; matches DataMem data
// PORTS
//  clk         in   1       single clock, rising edge
//  rst_n       in   1       asynchronous active-low reset
//  cpu_store   in   1       store request this cycle
//  cpu_load    in   1       load request this cycle
//  cpu_addr    in   ADDR_W  load/store word address
//  cpu_wdata   in   DATA_W  store data
//  cpu_rdata   out  DATA_W  load result, same cycle (combinational)
//  cpu_stall   out  1       store not accepted; CPU holds request and retries next cycle
//  mem_read    out  1       to DataMem MemRead
//  mem_write   out  1       to DataMem MemWrite; one-cycle pulse per drained entry
//  mem_addr    out  ADDR_W  to DataMem addr
//  mem_wdata   out  DATA_W  to DataMem write_data
//  mem_rdata   in   DATA_W  from DataMem read_data
//  sb_count    out  $clog2(DEPTH)+1  valid entries
//  sb_empty    out  1       sb_count==0
// BEHAVIOUR
//  State: DEPTH x {valid, addr, data}, head/tail pointers and count. No other FSM.
//  Reset (async, rst_n=0): all valid cleared, head=tail=count=0. Pending stores are discarded, including on reset mid-operation.
//   Outputs follow: mem_read=mem_write=0, cpu_stall=0, cpu_rdata=0 when no load, sb_empty=1.
//  hit = some valid entry addr==cpu_addr. At most one entry can match.
//  Load (cpu_load=1, cpu_store=0):
//   hit: cpu_rdata = entry data; mem_read=0; zero latency.
//   miss: mem_read=1, mem_addr=cpu_addr, cpu_rdata=mem_rdata in the same cycle; the port is busy, so no drain this cycle.
//  Store (cpu_store=1):
//   hit: overwrite the matching entry's data in place; count unchanged; accepted even when full.
//   miss and not full: write entry at tail, tail++, count++.
//   miss and full: cpu_stall=1, store not accepted; the drain fires this cycle, so the retry is accepted next cycle.
//   cpu_stall is combinational: full && cpu_store && !hit.
//  Drain: fires when count>0 and the cycle carries neither a load miss nor an accepted store.
//   On drain: mem_write=1, mem_addr/mem_wdata = head entry; clear valid, head++, count--. Order is oldest first.
//   An accepted store never coincides with a drain, so no same-slot conflict exists.
//  cpu_load and cpu_store both high is illegal. The block treats it as a store only: cpu_rdata=0, mem_read=0.
//  Pointers wrap modulo DEPTH. count saturates by construction (0..DEPTH).
//  When no access is driven: mem_addr/mem_wdata=0 and cpu_rdata=0.
//  Address width is 9 bits; DataMem decodes words 0..127. Upper-range addresses are passed through unchanged.
// STRUCTURE
//  Shared header mem_defs.vh: ADDR_W, DATA_W, default SB_DEPTH constants, common to DataMem and store_buffer.
//  One natural sub-module: sb_match, a combinational address compare giving a one-hot hit vector and the hit data.
//  Pointer/count logic and the port mux stay in store_buffer.
// TESTING
//  1 Reset: rst_n=0 then 1 -> sb_empty=1, sb_count=0, mem_write=0, mem_read=0, cpu_stall=0.
//  2 Forwarding: store 0x010<=0xDEADBEEF, next cycle load 0x010 -> cpu_rdata=0xDEADBEEF, mem_read=0.
//  3 Coalesce: store 0x005<=1, store 0x005<=2 -> sb_count=1; idle cycle -> one mem_write, addr 0x005, data 2; sb_empty=1.
//  4 Full: stores to 1,2,3,4 back-to-back, store to 9 -> cpu_stall=1 and mem_write addr1 that cycle; next cycle store accepted, sb_count=4.
//  5 Load miss with count=2: load 0x020, mem_rdata=0xA5A5A5A5 -> mem_read=1, mem_addr=0x020, cpu_rdata=0xA5A5A5A5, no mem_write, count stays 2.
//  6 Reset mid-operation: 3 entries, assert rst_n=0 asynchronously -> sb_count=0 immediately; after release, idle cycles produce no mem_write.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared constants and the per-cycle access classification for the posted-write
// store buffer that sits in front of the single-ported DataMem.
package store_buffer_pkg;

  localparam int SB_ADDR_W = 9;
  localparam int SB_DATA_W = 32;
  localparam int SB_DEPTH  = 4;

  // What the CPU side does with the buffer this cycle; draining is decided separately.
  typedef enum logic [2:0] {
    OP_IDLE,
    OP_LOAD_HIT,
    OP_LOAD_MISS,
    OP_STORE_HIT,
    OP_STORE_NEW,
    OP_STORE_STALL
  } sb_op_e;

  // A simultaneous load and store is treated as a store only.
  function automatic sb_op_e classify_op(input logic load, input logic store,
                                         input logic hit, input logic full);
    if (store) begin
      if (hit)       return OP_STORE_HIT;
      else if (full) return OP_STORE_STALL;
      else           return OP_STORE_NEW;
    end else if (load) begin
      return hit ? OP_LOAD_HIT : OP_LOAD_MISS;
    end
    return OP_IDLE;
  endfunction

endpackage

// File: rtl/sb_match.sv
// Combinational address compare over all buffer entries: one-hot hit vector plus
// the data of the (at most one) matching entry.
module sb_match #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic [DEPTH-1:0]  valid,
  input  logic [ADDR_W-1:0] entry_addr [DEPTH],
  input  logic [DATA_W-1:0] entry_data [DEPTH],
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [DEPTH-1:0]  hit_vec,
  output logic              hit,
  output logic [DATA_W-1:0] hit_data
);

  // Coalescing guarantees a single match, so an AND-OR mux replaces a priority chain.
  always_comb begin
    hit_vec  = '0;
    hit_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_vec[i] = valid[i] && (entry_addr[i] == cpu_addr);
      if (hit_vec[i]) hit_data = hit_data | entry_data[i];
    end
    hit = |hit_vec;
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write FIFO between the CPU load/store path and DataMem: coalesces
// same-address stores, forwards load hits, and drains oldest-first when the port is idle.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cpu_store,
  input  logic                   cpu_load,
  input  logic [ADDR_W-1:0]      cpu_addr,
  input  logic [DATA_W-1:0]      cpu_wdata,
  output logic [DATA_W-1:0]      cpu_rdata,
  output logic                   cpu_stall,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic [DATA_W-1:0]      mem_rdata,
  output logic [$clog2(DEPTH):0] sb_count,
  output logic                   sb_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0]  valid;
  logic [ADDR_W-1:0] entry_addr [DEPTH];
  logic [DATA_W-1:0] entry_data [DEPTH];
  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  count;

  logic [DEPTH-1:0]  hit_vec;
  logic              hit;
  logic [DATA_W-1:0] hit_data;
  logic              full;
  logic              drain;
  logic              alloc;
  logic [DEPTH-1:0]  wr_en;
  sb_op_e            op;

  sb_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_match (
    .valid      (valid),
    .entry_addr (entry_addr),
    .entry_data (entry_data),
    .cpu_addr   (cpu_addr),
    .hit_vec    (hit_vec),
    .hit        (hit),
    .hit_data   (hit_data)
  );

  assign full  = (count == CNT_W'(DEPTH));
  assign op    = classify_op(cpu_load, cpu_store, hit, full);
  assign alloc = (op == OP_STORE_NEW);

  // The port is free unless a load misses or a store is accepted; a stalled store
  // leaves it free, which is what lets the retry succeed on the following cycle.
  assign drain = (count != '0) && (op != OP_LOAD_MISS)
              && (op != OP_STORE_HIT) && (op != OP_STORE_NEW);

  assign cpu_stall = (op == OP_STORE_STALL);
  assign sb_count  = count;
  assign sb_empty  = (count == '0);

  // NOTE: every signal assigned in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_en = '0;
    if (op == OP_STORE_HIT)      wr_en = hit_vec;
    else if (op == OP_STORE_NEW) wr_en = DEPTH'(1) << tail;
  end

  always_comb begin
    cpu_rdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (op == OP_LOAD_HIT) begin
      cpu_rdata = hit_data;
    end else if (op == OP_LOAD_MISS) begin
      cpu_rdata = mem_rdata;
      mem_read  = 1'b1;
      mem_addr  = cpu_addr;
    end
    if (drain) begin
      mem_write = 1'b1;
      mem_addr  = entry_addr[head];
      mem_wdata = entry_data[head];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (alloc) begin
        valid[tail] <= 1'b1;
        tail        <= tail + PTR_W'(1);
        count       <= count + CNT_W'(1);
      end else if (drain) begin
        valid[head] <= 1'b0;
        head        <= head + PTR_W'(1);
        count       <= count - CNT_W'(1);
      end
    end
  end

  // NOTE: the address/data storage is deliberately not reset; valid alone qualifies it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en[i]) begin
        entry_addr[i] <= cpu_addr;
        entry_data[i] <= cpu_wdata;
      end
    end
  end

endmodule
